mux8_1_rr: RTL
==============

Name: mux8_1_rr

Overview:
- Collects 16-bit words from eight source channels onto one shared output, performing the reverse of the 1-to-8 demultiplexer.
- Uses round-robin arbitration with valid/ready handshakes on every channel and a registered output stage.
- Emits the 3-bit index of the source channel alongside each word, using the same selector encoding as the demux, so downstream logic can route responses back.

Parameters:
- WIDTH, 16, data width of each input and of the output word.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- input1..input8  input  WIDTH each  source data; inputN is channel N-1.
- in_valid  input  8  bit i = channel i holds a valid word.
- in_ready  output  8  bit i = channel i's word is accepted this cycle.
- output1  output  WIDTH  registered output word.
- selector  output  3  registered source index of output1 (input1=0 ... input8=7).
- out_valid  output  1  output1/selector hold a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- xfer_count  output  16  number of words accepted from inputs since reset; wraps.

Behaviour:
- Reset (async assert, sync deassert at the next edge):
  - out_valid=0, output1=0, selector=0, xfer_count=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready=0 while reset_n=0.
- Load condition: load_ok = !out_valid || out_ready (output register empty or draining this cycle).
- Arbitration (combinational):
  - Scan in_valid starting at rr_ptr, upward, wrapping 7→0.
  - The first set bit is the grant g.
  - No grant when in_valid=0.
- Input handshake: in_ready[g] = load_ok when a grant exists; all other in_ready bits are 0. At most one in_ready bit is high.
- Transfer, when in_ready[g] && in_valid[g]:
  - At the clock edge: output1 <= input(g+1), selector <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod 8.
  - xfer_count <= xfer_count+1; wraps 0xFFFF→0x0000.
- Drain with no new load (out_valid && out_ready, no grant): out_valid <= 0. output1 and selector keep their last values.
- Simultaneous drain and load: the new word replaces the old in the same edge and out_valid stays 1. This sustains 1 word/cycle throughput.
- Stall (out_valid && !out_ready):
  - output1, selector, out_valid, rr_ptr and xfer_count are all held.
  - All in_ready bits are 0.
  - A source holding valid must keep its data stable. The block does not check this.
- Latency: 1 cycle from input acceptance to out_valid.
- Fairness: after channel g is served, g has the lowest priority. With all 8 valid, grants rotate 0,1,...,7,0.
- in_ready depends combinationally on in_valid and out_ready, with no register path. in_valid must not depend on in_ready.
- Reset mid-operation: the pending output word is discarded and the state returns to the reset values immediately.

Optional Feature:
- Macro: MUX_FIXED_PRIORITY_EN.
- When defined:
  - The scan always starts at channel 0, so the lowest index wins.
  - rr_ptr is not implemented; grant is g = lowest set bit of in_valid.
- When undefined: round-robin as described above.
- All other behaviour (handshake, latency, counter, reset) is identical in both modes.

Test Plan:
- Reset, then only in_valid[3]=1 with input4=16'hA5A5, out_ready=1:
  - in_ready=8'b0000_1000 in that cycle.
  - Next cycle: out_valid=1, output1=16'hA5A5, selector=3, xfer_count=1.
- in_valid=8'hFF held, out_ready=1, inputN=N:
  - Selector sequence 0,1,...,7,0 on consecutive cycles, one word every cycle, with no bubbles.
  - Under MUX_FIXED_PRIORITY_EN the selector stays 0 on every cycle.
- Backpressure: word from channel 5 loaded, then out_ready=0 for 4 cycles with in_valid=8'h21:
  - output1 and selector=5 are held; in_ready=0 throughout.
  - When out_ready rises, channel 0 is granted next cycle. rr_ptr=6 wraps to 0 because in_valid=8'h21.
- Drain only: out_valid=1, out_ready=1, in_valid=0 → out_valid=0 next cycle and xfer_count unchanged.
- Counter wrap: preload by streaming 65536 single-channel transfers → xfer_count returns to 16'h0000 and out_valid stays correct.
- Assert reset_n=0 asynchronously mid-stall with out_valid=1:
  - Without waiting for a clock edge: out_valid=0, output1=0, selector=0, xfer_count=0, in_ready=0.
  - After release, the first grant starts at channel 0.

Source files
------------

// File: rtl/mux8_1_rr_if.sv
// Bundle of the eight source channels and the shared output port of mux8_1_rr.
// The slave modport is the mux side; master is the environment (sources and consumer).
interface mux8_1_rr_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [WIDTH-1:0] input3;
  logic [WIDTH-1:0] input4;
  logic [WIDTH-1:0] input5;
  logic [WIDTH-1:0] input6;
  logic [WIDTH-1:0] input7;
  logic [WIDTH-1:0] input8;
  logic [7:0]       in_valid;
  logic [7:0]       in_ready;
  logic [WIDTH-1:0] output1;
  logic [2:0]       selector;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      xfer_count;

  modport slave (
    input  input1, input2, input3, input4, input5, input6, input7, input8,
    input  in_valid, out_ready,
    output in_ready, output1, selector, out_valid, xfer_count
  );

  modport master (
    output input1, input2, input3, input4, input5, input6, input7, input8,
    output in_valid, out_ready,
    input  in_ready, output1, selector, out_valid, xfer_count
  );
endinterface

// File: rtl/mux8_1_rr.sv
// 8:1 round-robin valid/ready collector with a registered output stage and source index.
// Define MUX_FIXED_PRIORITY_EN for lowest-index-wins arbitration (no rotating pointer).
module mux8_1_rr #(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  mux8_1_rr_if.slave  bus
);

  logic [WIDTH-1:0] in_data [8];
  logic [2:0]       scan_base;
  logic             grant_vld;
  logic [2:0]       grant;
  logic             load_ok;
  logic             xfer;
  logic [7:0]       in_ready_c;

  logic [WIDTH-1:0] output1_q, output1_d;
  logic [2:0]       selector_q, selector_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      xfer_count_q, xfer_count_d;

  always_comb begin
    in_data[0] = bus.input1;
    in_data[1] = bus.input2;
    in_data[2] = bus.input3;
    in_data[3] = bus.input4;
    in_data[4] = bus.input5;
    in_data[5] = bus.input6;
    in_data[6] = bus.input7;
    in_data[7] = bus.input8;
  end

`ifdef MUX_FIXED_PRIORITY_EN
  assign scan_base = '0;
`else
  logic [2:0] rr_ptr_q, rr_ptr_d;

  assign scan_base = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) rr_ptr_d = grant + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Scan upward from scan_base; the 3-bit index sum wraps 7 -> 0 naturally.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!grant_vld && bus.in_valid[scan_base + 3'(i)]) begin
        grant_vld = 1'b1;
        grant     = scan_base + 3'(i);
      end
    end
  end

  assign load_ok = !out_valid_q || bus.out_ready;
  assign xfer    = grant_vld && load_ok;

  // Gated by reset_n so no source sees an accept while the block is held in reset.
  always_comb begin
    in_ready_c = '0;
    if (xfer && reset_n) in_ready_c[grant] = 1'b1;
  end

  always_comb begin
    output1_d    = output1_q;
    selector_d   = selector_q;
    out_valid_d  = out_valid_q;
    xfer_count_d = xfer_count_q;
    if (xfer) begin
      output1_d    = in_data[grant];
      selector_d   = grant;
      out_valid_d  = 1'b1;
      xfer_count_d = xfer_count_q + 16'd1;
    end else if (bus.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      output1_q    <= '0;
      selector_q   <= '0;
      out_valid_q  <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      output1_q    <= output1_d;
      selector_q   <= selector_d;
      out_valid_q  <= out_valid_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.output1    = output1_q;
  assign bus.selector   = selector_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.xfer_count = xfer_count_q;

endmodule
